// File: rtl/burst_rr_arbiter_pkg.sv
// burst_rr_arbiter_pkg
//   Shared definitions for the burst round-robin arbiter: FSM state
//   encoding and the index-width helper used to size source indices.
package burst_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Width of a source index; a single source still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_rr_arbiter_next_sel.sv
// rr_next_sel
//   Combinational round-robin pick. Searches ptr+1, ptr+2, ... (mod WIDTH)
//   for the first set request bit.
//   Ports:
//     req   in  WIDTH  request vector
//     ptr   in  IW     index of the last owner
//     sel   out IW     index of the next owner (valid when found)
//     found out 1      any request present
module rr_next_sel
    import burst_rr_arbiter_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int IW    = idx_w(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [IW-1:0]    sel,
    output logic             found
);

    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   rot;
    int                 start;
    int                 enc;

    // Rotate so bit 0 is the slot right after ptr, priority-encode the
    // lowest set bit, then map the offset back to a source index.
    always_comb begin
        start = (int'(ptr) + 1) % WIDTH;
        dbl   = {req, req};
        rot   = dbl[start +: WIDTH];
        enc   = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) enc = i;
        end
        found = |req;
        sel   = IW'((start + enc) % WIDTH);
    end

endmodule

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter
//   Shares one DATA_WIDTH readout path between WIDTH FWFT source FIFOs.
//   Each grant is a burst of up to BURST_MAX words; HOLD_REQ keeps the
//   grant across empty cycles so packets stay contiguous, and a hold
//   timeout forces release of a silent holder.
//   Ports:
//     BUS_CLK, BUS_RST        clock, synchronous active-high reset
//     WRITE_REQ[WIDTH]        source non-empty, word valid on DATA_IN
//     HOLD_REQ[WIDTH]         source asks to keep the grant
//     DATA_IN                 source i word at [i*DATA_WIDTH +: DATA_WIDTH]
//     READ_GRANT[WIDTH]       one-hot pop strobe (combinational)
//     READY_OUT               downstream accepts a word this cycle
//     WRITE_OUT, DATA_OUT     registered downstream write and word
//     GRANT_VALID, GRANT_ID   arbiter in GRANT, current owner
//     HOLD_TIMEOUT_ERR        one-cycle pulse on forced release
module burst_rr_arbiter
    import burst_rr_arbiter_pkg::*;
#(
    parameter int WIDTH        = 7,
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_MAX    = 16,
    parameter int HOLD_TIMEOUT = 255,
    localparam int IW          = idx_w(WIDTH)
) (
    input  logic                        BUS_CLK,
    input  logic                        BUS_RST,
    input  logic [WIDTH-1:0]            WRITE_REQ,
    input  logic [WIDTH-1:0]            HOLD_REQ,
    input  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0]            READ_GRANT,
    input  logic                        READY_OUT,
    output logic                        WRITE_OUT,
    output logic [DATA_WIDTH-1:0]       DATA_OUT,
    output logic                        GRANT_VALID,
    output logic [IW-1:0]               GRANT_ID,
    output logic                        HOLD_TIMEOUT_ERR
);

    // 9 bits covers counts up to 256 so compares against 255 never wrap.
    localparam int CW = 9;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   nxt_sel;
    logic            found;
    logic [CW-1:0]   burst_cnt;
    logic [CW-1:0]   idle_cnt;
    logic [CW-1:0]   burst_nxt;
    logic [CW-1:0]   idle_nxt;
    logic            own_wr;
    logic            own_hold;
    logic            rd;
    logic            timeout;
    logic            rel;

    rr_next_sel #(.WIDTH(WIDTH), .IW(IW)) u_next_sel (
        .req   (WRITE_REQ | HOLD_REQ),
        .ptr   (ptr),
        .sel   (nxt_sel),
        .found (found)
    );

    assign own_wr   = WRITE_REQ[sel];
    assign own_hold = HOLD_REQ[sel];

    // Holding owners may read past the burst limit.
    assign rd = (state == ST_GRANT) && READY_OUT && own_wr &&
                (own_hold || (burst_cnt < CW'(BURST_MAX)));

    always_comb begin
        READ_GRANT = '0;
        if (rd && !BUS_RST) READ_GRANT[sel] = 1'b1;
    end

    always_comb begin
        burst_nxt = burst_cnt;
        if (rd && (burst_cnt < CW'(BURST_MAX))) burst_nxt = burst_cnt + 1'b1;
        // Only an empty-but-holding owner accumulates idle time; any word
        // present (popped or stalled by READY_OUT) or hold low clears it.
        idle_nxt = '0;
        if (own_hold && !own_wr && (idle_cnt != '1)) idle_nxt = idle_cnt + 1'b1;
        else if (own_hold && !own_wr)                 idle_nxt = idle_cnt;
        timeout = (HOLD_TIMEOUT != 0) && own_hold && !own_wr &&
                  (idle_nxt >= CW'(HOLD_TIMEOUT));
        // Burst-limit release waits for READY_OUT so a stall never drops the grant.
        rel = (!own_hold && !own_wr) ||
              (!own_hold && READY_OUT && (burst_nxt >= CW'(BURST_MAX))) ||
              timeout;
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state            <= ST_IDLE;
            ptr              <= IW'(WIDTH - 1);
            sel              <= '0;
            burst_cnt        <= '0;
            idle_cnt         <= '0;
            WRITE_OUT        <= 1'b0;
            DATA_OUT         <= '0;
            HOLD_TIMEOUT_ERR <= 1'b0;
        end else begin
            WRITE_OUT        <= rd;
            HOLD_TIMEOUT_ERR <= 1'b0;
            if (rd) DATA_OUT <= DATA_IN[sel*DATA_WIDTH +: DATA_WIDTH];
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        sel       <= nxt_sel;
                        ptr       <= nxt_sel;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    burst_cnt <= burst_nxt;
                    idle_cnt  <= idle_nxt;
                    if (rel) begin
                        state            <= ST_IDLE;
                        HOLD_TIMEOUT_ERR <= timeout;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign GRANT_VALID = (state == ST_GRANT);
    assign GRANT_ID    = sel;

endmodule
